// File: rtl/event_encoder8to3.sv
// Event-request encoder: latches 8 request lines as pending events and
// presents them one at a time, by priority, over a valid/ready output.
module event_encoder8to3 #(
    parameter bit PRIO_HIGH = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       out_ready,
    input  logic       clr_ovf,
    output logic       out_valid,
    output logic [2:0] out_code,
    output logic [7:0] pending,
    output logic       ovf
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] pend_reg;
    logic [7:0] pend_nxt;
    logic [7:0] ack_mask;
    logic [2:0] code_reg;
    logic [2:0] code_nxt;
    logic       ovf_reg;
    logic       ovf_nxt;
    logic       ovf_set;
    logic       hs;
    logic       reload;

    // Later matches overwrite earlier ones, so scan order sets the winner.
    function automatic logic [2:0] prio(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (PRIO_HIGH) begin
                if (v[i]) idx = 3'(i);
            end else begin
                if (v[7-i]) idx = 3'(7 - i);
            end
        end
        return idx;
    endfunction

    assign hs       = (state == PRESENT) & out_ready;
    assign ack_mask = hs ? (8'd1 << code_reg) : 8'd0;
    assign pend_nxt = (pend_reg & ~ack_mask) | req;
    assign ovf_set  = |(req & pend_reg & ~ack_mask);
    assign reload   = (state == IDLE) | hs;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_reg <= 8'h00;
            code_reg <= 3'd0;
            ovf_reg  <= 1'b0;
        end else begin
            pend_reg <= pend_nxt;
            code_reg <= code_nxt;
            ovf_reg  <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        code_nxt  = code_reg;
        if (reload) begin
            if (|pend_nxt) begin
                state_nxt = PRESENT;
                code_nxt  = prio(pend_nxt);
            end else begin
                state_nxt = IDLE;
            end
        end
        // A fresh coalesce outranks a clear in the same cycle.
        ovf_nxt = ovf_reg;
        if (ovf_set) begin
            ovf_nxt = 1'b1;
        end else if (clr_ovf) begin
            ovf_nxt = 1'b0;
        end
    end

    always_comb begin
        out_valid = (state == PRESENT);
        out_code  = code_reg;
        pending   = pend_reg;
        ovf       = ovf_reg;
    end

endmodule

// File: tb/tb_event_encoder8to3.sv
// Scoreboard bench for event_encoder8to3: directed vectors push expected
// post-edge state; a monitor pops and compares after every clock edge.
module tb_event_encoder8to3;

    typedef struct {
        logic       v;
        logic [2:0] c;
        logic       cc;
        logic [7:0] p;
        logic       o;
        int         lc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       out_ready;
    logic       clr_ovf;
    logic       out_valid;
    logic [2:0] out_code;
    logic [7:0] pending;
    logic       ovf;
    logic       lo_valid;
    logic [2:0] lo_code;
    logic [7:0] lo_pending;
    logic       lo_ovf;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   step_no = 0;

    always #5 clk = ~clk;

    event_encoder8to3 #(.PRIO_HIGH(1'b1)) dut_hi (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .clr_ovf   (clr_ovf),
        .out_valid (out_valid),
        .out_code  (out_code),
        .pending   (pending),
        .ovf       (ovf)
    );

    event_encoder8to3 #(.PRIO_HIGH(1'b0)) dut_lo (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .clr_ovf   (clr_ovf),
        .out_valid (lo_valid),
        .out_code  (lo_code),
        .pending   (lo_pending),
        .ovf       (lo_ovf)
    );

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if (out_valid !== e.v) begin
                miscompares++;
                $display("FAIL vec%0d valid: got %b want %b",
                         vectors, out_valid, e.v);
            end
            if ((e.v || e.cc) && out_code !== e.c) begin
                miscompares++;
                $display("FAIL vec%0d code: got %0d want %0d",
                         vectors, out_code, e.c);
            end
            if (pending !== e.p) begin
                miscompares++;
                $display("FAIL vec%0d pending: got %h want %h",
                         vectors, pending, e.p);
            end
            if (ovf !== e.o) begin
                miscompares++;
                $display("FAIL vec%0d ovf: got %b want %b",
                         vectors, ovf, e.o);
            end
            if (e.lc >= 0 && lo_code !== 3'(e.lc)) begin
                miscompares++;
                $display("FAIL vec%0d lo_code: got %0d want %0d",
                         vectors, lo_code, e.lc);
            end
            if (e.lc >= 0 && lo_valid !== e.v) begin
                miscompares++;
                $display("FAIL vec%0d lo_valid: got %b want %b",
                         vectors, lo_valid, e.v);
            end
        end
    end

    task automatic step(input logic rs, input logic [7:0] rq,
                        input logic rdy, input logic clr,
                        input logic ev, input logic [2:0] ec,
                        input logic cc, input logic [7:0] ep,
                        input logic eo, input int lc);
        exp_t e;
        @(negedge clk);
        rst_n     = rs;
        req       = rq;
        out_ready = rdy;
        clr_ovf   = clr;
        e.v  = ev;
        e.c  = ec;
        e.cc = cc;
        e.p  = ep;
        e.o  = eo;
        e.lc = lc;
        sb.push_back(e);
        step_no++;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 8'h00;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        // reset state
        step(0, 8'h00, 0, 0, 0, 3'd0, 1, 8'h00, 0, 0);
        step(0, 8'h10, 1, 0, 0, 3'd0, 1, 8'h00, 0, -1);
        // single event, 1-cycle latency
        step(1, 8'h10, 1, 0, 1, 3'd4, 0, 8'h10, 0, 4);
        step(1, 8'h00, 1, 0, 0, 3'd4, 1, 8'h00, 0, -1);
        // priority drain, both priority orders
        step(1, 8'hA5, 1, 0, 1, 3'd7, 0, 8'hA5, 0, 0);
        step(1, 8'h00, 1, 0, 1, 3'd5, 0, 8'h25, 0, 2);
        step(1, 8'h00, 1, 0, 1, 3'd2, 0, 8'h05, 0, 5);
        step(1, 8'h00, 1, 0, 1, 3'd0, 0, 8'h01, 0, 7);
        step(1, 8'h00, 1, 0, 0, 3'd0, 1, 8'h00, 0, 7);
        // backpressure holds code against higher request
        step(1, 8'h08, 0, 0, 1, 3'd3, 0, 8'h08, 0, -1);
        step(1, 8'h80, 0, 0, 1, 3'd3, 0, 8'h88, 0, -1);
        step(1, 8'h00, 0, 0, 1, 3'd3, 0, 8'h88, 0, -1);
        step(1, 8'h00, 1, 0, 1, 3'd7, 0, 8'h80, 0, -1);
        step(1, 8'h00, 1, 0, 0, 3'd7, 1, 8'h00, 0, -1);
        // overflow set / clear / set-beats-clear
        step(1, 8'h02, 0, 0, 1, 3'd1, 0, 8'h02, 0, -1);
        step(1, 8'h02, 0, 0, 1, 3'd1, 0, 8'h02, 1, -1);
        step(1, 8'h02, 0, 0, 1, 3'd1, 0, 8'h02, 1, -1);
        step(1, 8'h00, 0, 1, 1, 3'd1, 0, 8'h02, 0, -1);
        step(1, 8'h02, 0, 1, 1, 3'd1, 0, 8'h02, 1, -1);
        step(1, 8'h00, 0, 1, 1, 3'd1, 0, 8'h02, 0, -1);
        step(1, 8'h00, 1, 0, 0, 3'd1, 1, 8'h00, 0, -1);
        // re-pend on acknowledge, no overflow
        step(1, 8'h40, 0, 0, 1, 3'd6, 0, 8'h40, 0, -1);
        step(1, 8'h40, 1, 0, 1, 3'd6, 0, 8'h40, 0, -1);
        step(1, 8'h00, 1, 0, 0, 3'd6, 1, 8'h00, 0, -1);
        // reset mid-operation
        step(1, 8'hFF, 0, 0, 1, 3'd7, 0, 8'hFF, 0, -1);
        step(1, 8'h80, 0, 0, 1, 3'd7, 0, 8'hFF, 1, -1);
        step(0, 8'hFF, 1, 0, 0, 3'd0, 1, 8'h00, 0, -1);
        step(1, 8'h01, 0, 0, 1, 3'd0, 0, 8'h01, 0, -1);
        step(1, 8'h00, 1, 0, 0, 3'd0, 1, 8'h00, 0, -1);
        @(negedge clk);
        req       = 8'h00;
        out_ready = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0 || vectors != step_no) begin
            miscompares++;
            $display("FAIL drain: got %0d checked want %0d",
                     vectors, step_no);
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/event_encoder8to3.md
EVENT_ENCODER8TO3 -- requirements
Module: event_encoder8to3

Interface
REQ-001 SHALL have parameter PRIO_HIGH, default 1, meaning 1 = bit 7 highest priority and 0 = bit 0 highest priority.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, reset that is synchronous and active-low.
REQ-004 SHALL have port req, input, 8 bits, one event-request line per source, each high for one or more cycles.
REQ-005 SHALL have port out_ready, input, 1 bit, meaning the consumer accepts out_code this cycle.
REQ-006 SHALL have port clr_ovf, input, 1 bit, a synchronous clear of ovf.
REQ-007 SHALL have port out_valid, output, 1 bit, meaning out_code holds a valid encoded event.
REQ-008 SHALL have port out_code, output, 3 bits, the binary index of the presented event.
REQ-009 SHALL have port pending, output, 8 bits, the registered set of events not yet accepted, including the one presented.
REQ-010 SHALL have port ovf, output, 1 bit, a sticky flag meaning a request was coalesced into an already-pending bit.

Function
REQ-011 SHALL define handshake hs = out_valid & out_ready, and ack_mask = one-hot(out_code) when hs is 1, else 0.
REQ-012 SHALL compute pend_nxt = (pending & ~ack_mask) | req, and register it into pending every cycle.
REQ-013 SHALL implement two states: IDLE (out_valid=0) and PRESENT (out_valid=1).
REQ-014 SHALL reload the output in IDLE or on hs: out_valid <= |pend_nxt; out_code <= prio(pend_nxt).
REQ-015 SHALL hold out_valid and out_code stable in PRESENT without hs, even if a higher-priority request arrives.
REQ-016 SHALL make prio() return the highest set index when PRIO_HIGH=1 and the lowest set index when PRIO_HIGH=0.
REQ-017 SHALL leave out_code at its last value when pend_nxt is 0 at a reload; the value is don't-care while out_valid=0.
REQ-018 SHALL have latency of 1 cycle: req[i] in cycle t with the block idle gives out_valid=1 and out_code=i in cycle t+1.
REQ-019 SHALL sustain one accepted event per cycle while out_ready=1 and pending is non-empty.
REQ-020 SHALL, when req[i]=1 in the same cycle bit i is acknowledged, re-pend bit i (set wins) without setting ovf.
REQ-021 SHALL set ovf <= 1 when req[i]=1 while pending[i]=1 and bit i is not acknowledged that cycle.
REQ-022 SHALL apply ovf priority as: set beats clr_ovf in the same cycle; otherwise clr_ovf=1 clears ovf.
REQ-023 SHALL treat multiple simultaneous req bits as independent pending events, presented in priority order.

Reset
REQ-024 SHALL, when rst_n=0 at a clock edge, drive pending=8'h00, out_valid=0, out_code=3'b000, ovf=0, and state IDLE.
REQ-025 SHALL discard, during reset, all in-flight and pending events and ignore req.
REQ-026 SHALL accept req in the first cycle after rst_n returns to 1, with normal 1-cycle latency.

Verification
REQ-027 SHALL cover a single event: PRIO_HIGH=1, idle, req=8'h10 for one cycle, out_ready=1 -> next cycle out_valid=1, out_code=3'd4, pending=8'h10; following cycle out_valid=0, pending=8'h00.
REQ-028 SHALL cover priority drain: PRIO_HIGH=1, req=8'hA5 for one cycle, out_ready=1 -> out_code 7,5,2,0 on consecutive cycles, then out_valid=0; with PRIO_HIGH=0 the order is 0,2,5,7.
REQ-029 SHALL cover backpressure: out_ready=0 while code 3 is presented, then req=8'h80 -> out_code stays 3 and pending=8'h88; raise out_ready -> next cycle out_code=7.
REQ-030 SHALL cover overflow: req[1] pulsed twice while bit 1 is pending and out_ready=0 -> ovf=1; clr_ovf pulse -> ovf=0; clr_ovf concurrent with a new coalesce -> ovf stays 1.
REQ-031 SHALL cover re-pend on acknowledge: code 6 presented, out_ready=1 and req[6]=1 in the same cycle -> next cycle out_valid=1, out_code=6, ovf=0.
REQ-032 SHALL cover reset mid-operation: pending=8'hFF, rst_n=0 for one edge -> pending=8'h00, out_valid=0, ovf=0; req=8'h01 in the first post-reset cycle -> out_code=0 the next cycle.
